// File: rtl/rvr32_wb_stage.sv
// Rover32 writeback stage.
// Drives the single write port of the general register file. It merges
// in-order pipeline results with out-of-band results from the long-latency
// unit, which are queued in a 2-entry FIFO. A starvation counter stalls the
// pipeline for one cycle so a queued late result eventually wins the port.
//
// Build option: define RVR32_WB_LOAD_ALIGN_EN to enable load-data
// alignment and sign/zero extension. When it is undefined, pipe_data is
// written unmodified and pipe_load/pipe_funct3/pipe_boff are ignored.

module rvr32_wb_stage #(
   // Consecutive lost arbitrations with a non-empty FIFO before the
   // pipeline is stalled (legal range 1..15).
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        pipe_load,
   input  logic [2:0]  pipe_funct3,
   input  logic [1:0]  pipe_boff,
   output logic        pipe_stall,
   input  logic        late_valid,
   output logic        late_ready,
   input  logic [4:0]  late_rd,
   input  logic [31:0] late_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

`ifdef RVR32_WB_LOAD_ALIGN_EN
   // Select the addressed byte/half of a raw load word and extend it.
   // Halfword accesses ignore offset bit 0.
   function automatic logic [31:0] load_align(input logic [31:0] data,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  boff);
      logic [7:0]  sel_byte;
      logic [15:0] sel_half;
      logic [31:0] res;
      case (boff)
         2'd0:    sel_byte = data[7:0];
         2'd1:    sel_byte = data[15:8];
         2'd2:    sel_byte = data[23:16];
         2'd3:    sel_byte = data[31:24];
         default: sel_byte = data[7:0];
      endcase
      sel_half = boff[1] ? data[31:16] : data[15:0];
      case (funct3)
         3'b000:  res = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  res = {{16{sel_half[15]}}, sel_half};
         3'b100:  res = {24'd0, sel_byte};
         3'b101:  res = {16'd0, sel_half};
         default: res = data;
      endcase
      return res;
   endfunction
`endif

   // FIFO storage and bookkeeping
   logic [4:0]  fifo_rd_r   [2];
   logic [31:0] fifo_data_r [2];
   logic        head_r;
   logic [1:0]  count_r;
   logic [3:0]  starve_r;

   // Per-cycle decisions
   logic        fifo_nonempty_s;
   logic        pipe_req_s;
   logic        late_push_s;
   logic        pop_s;
   logic        pipe_win_s;
   logic        wr_ptr_s;
   logic [31:0] pipe_wdata_s;

   assign fifo_nonempty_s = (count_r != 2'd0);
   assign pipe_stall      = (starve_r == STARVE_LIM) && fifo_nonempty_s;
   assign late_ready      = !rst && (count_r != 2'd2);

   // Pipeline result value after optional load alignment
   always_comb begin
      pipe_wdata_s = pipe_data;
`ifdef RVR32_WB_LOAD_ALIGN_EN
      if (pipe_load) begin
         pipe_wdata_s = load_align(pipe_data, pipe_funct3, pipe_boff);
      end else begin
         pipe_wdata_s = pipe_data;
      end
`endif
   end

`ifndef RVR32_WB_LOAD_ALIGN_EN
   // Load-format inputs are intentionally unused in this build.
   logic unused_load_s;
   assign unused_load_s = &{1'b0, pipe_load, pipe_funct3, pipe_boff};
`endif

   // Port arbitration and FIFO push decision
   always_comb begin
      pipe_req_s  = pipe_valid && (pipe_rd != 5'd0);
      late_push_s = late_valid && late_ready && (late_rd != 5'd0);
      pop_s       = 1'b0;
      pipe_win_s  = 1'b0;
      if (pipe_stall) begin
         pop_s = 1'b1;
      end else if (pipe_req_s) begin
         pipe_win_s = 1'b1;
      end else if (fifo_nonempty_s) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      // Tail slot: head when empty, the other slot when one entry is held.
      wr_ptr_s = head_r ^ (count_r == 2'd1);
   end

   // Late-result FIFO: push at tail, pop at head, strict FIFO order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r         <= 1'b0;
         count_r        <= 2'd0;
         fifo_rd_r[0]   <= 5'd0;
         fifo_rd_r[1]   <= 5'd0;
         fifo_data_r[0] <= 32'd0;
         fifo_data_r[1] <= 32'd0;
      end else begin
         if (late_push_s) begin
            fifo_rd_r[wr_ptr_s]   <= late_rd;
            fifo_data_r[wr_ptr_s] <= late_data;
         end
         if (pop_s) begin
            head_r <= ~head_r;
         end
         case ({late_push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Starvation counter: counts pipe wins over a waiting late result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_r <= 4'd0;
      end else if (pop_s) begin
         starve_r <= 4'd0;
      end else if (fifo_nonempty_s && pipe_win_s && (starve_r != STARVE_LIM)) begin
         starve_r <= starve_r + 4'd1;
      end else begin
         starve_r <= starve_r;
      end
   end

   // Registered register-file write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= 5'd0;
         rf_wdata <= 32'd0;
      end else if (pop_s) begin
         rf_we    <= 1'b1;
         rf_waddr <= fifo_rd_r[head_r];
         rf_wdata <= fifo_data_r[head_r];
      end else if (pipe_win_s) begin
         rf_we    <= 1'b1;
         rf_waddr <= pipe_rd;
         rf_wdata <= pipe_wdata_s;
      end else begin
         rf_we    <= 1'b0;
         rf_waddr <= rf_waddr;
         rf_wdata <= rf_wdata;
      end
   end

endmodule

// File: tb/tb_rvr32_wb_stage.sv
// Self-checking bench for rvr32_wb_stage: a vector table for the pipe path
// and load alignment, plus hand-written multi-cycle sequences for the FIFO,
// starvation stall and mid-operation reset.

module tb_rvr32_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        pipe_load;
   logic [2:0]  pipe_funct3;
   logic [1:0]  pipe_boff;
   logic        pipe_stall;
   logic        late_valid;
   logic        late_ready;
   logic [4:0]  late_rd;
   logic [31:0] late_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int total = 0;
   int bad   = 0;

`ifdef RVR32_WB_LOAD_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   localparam logic [31:0] RAW = 32'h80FF_7F01;

   rvr32_wb_stage #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .pipe_load(pipe_load), .pipe_funct3(pipe_funct3), .pipe_boff(pipe_boff),
      .pipe_stall(pipe_stall),
      .late_valid(late_valid), .late_ready(late_ready),
      .late_rd(late_rd), .late_data(late_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        load;
      logic [2:0]  funct3;
      logic [1:0]  boff;
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_in();
      pipe_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
      pipe_load = 1'b0; pipe_funct3 = 3'd0; pipe_boff = 2'd0;
      late_valid = 1'b0; late_rd = 5'd0; late_data = 32'd0;
   endtask

   task automatic drv_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
      pipe_valid = v; pipe_rd = rd; pipe_data = d;
      pipe_load = 1'b0; pipe_funct3 = 3'd0; pipe_boff = 2'd0;
   endtask

   task automatic drv_late(input logic v, input logic [4:0] rd, input logic [31:0] d);
      late_valid = v; late_rd = rd; late_data = d;
   endtask

   task automatic chk_wr(input string name, input logic [4:0] rd, input logic [31:0] d);
      chk({name, "_we"},   32'(rf_we),    32'd1);
      chk({name, "_addr"}, 32'(rf_waddr), 32'(rd));
      chk({name, "_data"}, rf_wdata,      d);
   endtask

   initial begin
      // valid rd data load funct3 boff exp_we exp_wdata
      vecs[0]  = '{1'b1, 5'd5,  32'h1234_5678, 1'b0, 3'b000, 2'd0, 1'b1, 32'h1234_5678};
      vecs[1]  = '{1'b1, 5'd6,  RAW, 1'b1, 3'b000, 2'd3, 1'b1, ALIGN ? 32'hFFFF_FF80 : RAW};
      vecs[2]  = '{1'b1, 5'd7,  RAW, 1'b1, 3'b100, 2'd1, 1'b1, ALIGN ? 32'h0000_007F : RAW};
      vecs[3]  = '{1'b1, 5'd8,  RAW, 1'b1, 3'b001, 2'd2, 1'b1, ALIGN ? 32'hFFFF_80FF : RAW};
      vecs[4]  = '{1'b1, 5'd9,  RAW, 1'b1, 3'b101, 2'd0, 1'b1, ALIGN ? 32'h0000_7F01 : RAW};
      vecs[5]  = '{1'b1, 5'd10, RAW, 1'b1, 3'b001, 2'd3, 1'b1, ALIGN ? 32'hFFFF_80FF : RAW};
      vecs[6]  = '{1'b1, 5'd11, RAW, 1'b1, 3'b101, 2'd1, 1'b1, ALIGN ? 32'h0000_7F01 : RAW};
      vecs[7]  = '{1'b1, 5'd12, RAW, 1'b1, 3'b000, 2'd2, 1'b1, ALIGN ? 32'hFFFF_FFFF : RAW};
      vecs[8]  = '{1'b1, 5'd13, RAW, 1'b1, 3'b010, 2'd0, 1'b1, RAW};
      vecs[9]  = '{1'b1, 5'd14, RAW, 1'b1, 3'b011, 2'd1, 1'b1, RAW};
      vecs[10] = '{1'b1, 5'd15, RAW, 1'b0, 3'b000, 2'd3, 1'b1, RAW};
      vecs[11] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 3'b000, 2'd0, 1'b0, 32'd0};
      vecs[12] = '{1'b0, 5'd31, 32'hCAFE_F00D, 1'b0, 3'b000, 2'd0, 1'b0, 32'd0};
      vecs[13] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b0, 3'b000, 2'd0, 1'b1, 32'hA5A5_A5A5};

      // Reset state
      rst = 1'b1;
      idle_in();
      @(negedge clk);
      chk("rst_we",    32'(rf_we),      32'd0);
      chk("rst_addr",  32'(rf_waddr),   32'd0);
      chk("rst_data",  rf_wdata,        32'd0);
      chk("rst_stall", 32'(pipe_stall), 32'd0);
      chk("rst_ready", 32'(late_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_we",    32'(rf_we),      32'd0);
      chk("post_rst_ready", 32'(late_ready), 32'd1);

      // Pipe path and load alignment vectors
      for (int i = 0; i < 14; i++) begin
         pipe_valid = vecs[i].valid; pipe_rd = vecs[i].rd; pipe_data = vecs[i].data;
         pipe_load = vecs[i].load; pipe_funct3 = vecs[i].funct3; pipe_boff = vecs[i].boff;
         @(negedge clk);
         chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_data", i), rf_wdata, vecs[i].exp_wdata);
         end
      end
      idle_in();
      @(negedge clk);
      chk("idle_we", 32'(rf_we), 32'd0);

      // Late results back to back with the pipe idle
      chk("b2b_ready0", 32'(late_ready), 32'd1);
      drv_late(1'b1, 5'd7, 32'h0000_0777);
      @(negedge clk);
      chk("b2b_we_idle", 32'(rf_we), 32'd0);
      chk("b2b_ready1", 32'(late_ready), 32'd1);
      drv_late(1'b1, 5'd9, 32'h0000_0999);
      @(negedge clk);
      chk_wr("b2b_w7", 5'd7, 32'h0000_0777);
      chk("b2b_ready2", 32'(late_ready), 32'd1);
      drv_late(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk_wr("b2b_w9", 5'd9, 32'h0000_0999);
      @(negedge clk);
      chk("b2b_end_we", 32'(rf_we), 32'd0);

      // rd=0 on both sources: consumed, never written, no stall
      drv_pipe(1'b1, 5'd0, 32'h1111_1111);
      drv_late(1'b1, 5'd0, 32'h2222_2222);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rd0_we%0d", i),    32'(rf_we),      32'd0);
         chk($sformatf("rd0_stall%0d", i), 32'(pipe_stall), 32'd0);
         chk($sformatf("rd0_ready%0d", i), 32'(late_ready), 32'd1);
      end
      idle_in();
      @(negedge clk);
      chk("rd0_after_we", 32'(rf_we), 32'd0);

      // Fill the FIFO while the pipe is busy; late_ready drops at 2 entries
      drv_pipe(1'b1, 5'd1, 32'h0000_0201);
      drv_late(1'b1, 5'd20, 32'h0000_2020);
      @(negedge clk);
      chk_wr("fill_p1", 5'd1, 32'h0000_0201);
      chk("fill_ready1", 32'(late_ready), 32'd1);
      drv_pipe(1'b1, 5'd2, 32'h0000_0202);
      drv_late(1'b1, 5'd21, 32'h0000_2121);
      @(negedge clk);
      chk_wr("fill_p2", 5'd2, 32'h0000_0202);
      chk("fill_ready_full", 32'(late_ready), 32'd0);
      drv_pipe(1'b1, 5'd3, 32'h0000_0203);
      drv_late(1'b1, 5'd22, 32'h0000_2222);
      @(negedge clk);
      chk_wr("fill_p3", 5'd3, 32'h0000_0203);
      chk("fill_ready_full2", 32'(late_ready), 32'd0);
      chk("fill_stall", 32'(pipe_stall), 32'd0);
      idle_in();
      @(negedge clk);
      chk_wr("fill_pop20", 5'd20, 32'h0000_2020);
      chk("fill_ready_back", 32'(late_ready), 32'd1);
      @(negedge clk);
      chk_wr("fill_pop21", 5'd21, 32'h0000_2121);
      @(negedge clk);
      chk("fill_no22", 32'(rf_we), 32'd0);

      // Starvation: pipe writes every cycle, one late entry waiting
      begin
         logic [4:0] exp_addr  [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11, 5'd6};
         logic       exp_stall [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
         int  idx = 1;
         logic prev_stall = 1'b0;
         for (int i = 0; i < 7; i++) begin
            drv_pipe(1'b1, 5'(idx), 32'h100 + 32'(idx));
            if (i == 0) drv_late(1'b1, 5'd11, 32'hDEAD_0011);
            else        drv_late(1'b0, 5'd0, 32'd0);
            @(negedge clk);
            chk_wr($sformatf("starve%0d", i), exp_addr[i],
                   (exp_addr[i] == 5'd11) ? 32'hDEAD_0011 : 32'h100 + 32'(exp_addr[i]));
            chk($sformatf("starve%0d_stall", i), 32'(pipe_stall), 32'(exp_stall[i]));
            if (!prev_stall) idx++;
            prev_stall = exp_stall[i];
         end
         idle_in();
         @(negedge clk);
         chk("starve_end_we", 32'(rf_we), 32'd0);
      end

      // Reset asserted with 2 FIFO entries and a write in flight
      drv_pipe(1'b1, 5'd1, 32'h0000_0301);
      drv_late(1'b1, 5'd24, 32'h0000_2424);
      @(negedge clk);
      drv_pipe(1'b1, 5'd2, 32'h0000_0302);
      drv_late(1'b1, 5'd25, 32'h0000_2525);
      @(negedge clk);
      chk_wr("mrst_pre", 5'd2, 32'h0000_0302);
      chk("mrst_pre_ready", 32'(late_ready), 32'd0);
      idle_in();
      #2 rst = 1'b1;
      #1;
      chk("mrst_we",    32'(rf_we),      32'd0);
      chk("mrst_ready", 32'(late_ready), 32'd0);
      chk("mrst_stall", 32'(pipe_stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_rel_ready", 32'(late_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mrst_stale%0d", i), 32'(rf_we), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rvr32_wb_stage.md
# rvr32_wb_stage

Writeback stage of the Rover32 core. It sits directly upstream of the general register file and drives its single write port (write enable, write address, write data). It merges two result sources: in-order results from the main pipeline, and out-of-band results from the long-latency unit (mul/div, load miss). Load data is aligned and extended here, and late results are buffered in a 2-entry FIFO. A starvation guard ensures late results eventually win the port.

## Interface
- STARVE_MAX, 4: consecutive lost arbitrations with a non-empty FIFO before the pipeline is stalled (1..15).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pipe_valid  in  1  pipeline result present.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result (raw load word when pipe_load=1).
- pipe_load  in  1  result is load data.
- pipe_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- pipe_boff  in  2  load byte offset (address[1:0]).
- pipe_stall  out  1  pipeline result not consumed this cycle; upstream holds its inputs.
- late_valid  in  1  late result offered.
- late_ready  out  1  FIFO can accept a late result.
- late_rd  in  5  late destination register.
- late_data  in  32  late result.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).

## Operation
- Pipe write request: pipe_valid=1 and pipe_rd!=0. A pipe_valid=1 result with pipe_rd=0 is consumed and dropped.
- Late handshake: late_valid && late_ready.
  - On handshake with late_rd!=0, the result is pushed to the FIFO.
  - On handshake with late_rd=0, the result is consumed and dropped.
- late_ready = !rst && FIFO count<2. There is no pass-through when full, even if a pop occurs in the same cycle.
- Port arbitration, each cycle:
  - If pipe_stall=1: the FIFO head wins; the pipe input is ignored.
  - Otherwise, if there is a pipe write request: pipe wins.
  - Otherwise, if the FIFO is non-empty: the FIFO head wins (pop).
  - Otherwise: idle; rf_we=0 next cycle.
- Starvation counter `starve`, width 4 bits:
  - Cleared on every FIFO pop.
  - Incremented when the FIFO is non-empty and a pipe write wins.
  - Saturates at STARVE_MAX.
- pipe_stall = (starve==STARVE_MAX) && FIFO non-empty. This is combinational from registered state only.
- Load alignment (see Configuration): select byte or half at pipe_boff.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Half at boff 1 or 3 is treated as boff 0 or 2 (bit 0 ignored).
  - Other funct3 values: pass through.
- Same-rd ordering between pipe and late sources is guaranteed by upstream issue logic; this block does not check it.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, starve=0, pipe_stall=0, late_ready=0.
- Pipe result at edge N → rf_* valid after edge N; the register file writes at edge N+1.
- Late handshake at edge N → FIFO entry exists after N; earliest pop at N+1 → rf_* valid after N+1.
- Push and pop in the same cycle are allowed; the count is unchanged.
- Pop with count=1 and a simultaneous push: the new entry becomes the head.
- FIFO order is strict first-in, first-out.
- Reset asserted mid-operation: FIFO contents are lost, rf_we clears immediately (asynchronously), and starve clears.
- pipe_stall lasts exactly one cycle per pop. starve clears on the pop, so pipe_stall drops the following cycle unless STARVE_MAX is reached again.

## Configuration
- RVR32_WB_LOAD_ALIGN_EN defined: alignment and extension as described in Operation.
- RVR32_WB_LOAD_ALIGN_EN undefined: pipe_data is written unmodified. pipe_load, pipe_funct3 and pipe_boff remain as ports but are ignored. All other behaviour is identical.

## Test plan
- Reset release, then pipe_valid=1, rd=5, data=0x1234_5678 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678; before that cycle all rf_* outputs are 0.
- Load alignment (macro on): data=0x80FF_7F01.
  - LB boff=3 → 0xFFFF_FF80.
  - LBU boff=1 → 0x0000_007F.
  - LH boff=2 → 0xFFFF_80FF.
  - LHU boff=0 → 0x0000_7F01.
  - With the macro off, every case → 0x80FF_7F01.
- Late results rd=7 then rd=9 offered back to back while the pipe is idle → late_ready=0 only after 2 entries are queued without a pop; writes to 7, then 9, one cycle apart.
- Pipe writes every cycle with 1 FIFO entry, STARVE_MAX=4 → after 4 pipe wins, pipe_stall=1 for one cycle, the FIFO entry is written, the stalled pipe result is written the next cycle, and no result is lost.
- pipe rd=0 and late rd=0 handshakes → rf_we stays 0, the FIFO stays empty, and the pipe is not stalled.
- Reset asserted with 2 FIFO entries and rf_we=1 → rf_we=0 immediately; after release late_ready=1 and no stale writes occur.
